// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage load/store engine: load/store
// code constants, FSM state encoding and the size/alignment helpers used
// by both the access unit and the load extractor.
package mem_pkg;

   // Unified load/store codes produced by instruction decode
   localparam logic [2:0] LS_LB  = 3'b000;
   localparam logic [2:0] LS_LBU = 3'b001;
   localparam logic [2:0] LS_LH  = 3'b010;
   localparam logic [2:0] LS_LHU = 3'b011;
   localparam logic [2:0] LS_LW  = 3'b100;
   localparam logic [2:0] LS_SB  = 3'b101;
   localparam logic [2:0] LS_SH  = 3'b110;
   localparam logic [2:0] LS_SW  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DRAIN
   } state_e;

   function automatic logic is_store(input logic [2:0] code);
      return (code == LS_SB) || (code == LS_SH) || (code == LS_SW);
   endfunction

   function automatic logic is_byte(input logic [2:0] code);
      return (code == LS_LB) || (code == LS_LBU) || (code == LS_SB);
   endfunction

   function automatic logic is_half(input logic [2:0] code);
      return (code == LS_LH) || (code == LS_LHU) || (code == LS_SH);
   endfunction

   function automatic logic is_word(input logic [2:0] code);
      return (code == LS_LW) || (code == LS_SW);
   endfunction

   // Only lb and lh sign-extend; every other load zero-extends or is full width
   function automatic logic is_signed_load(input logic [2:0] code);
      return (code == LS_LB) || (code == LS_LH);
   endfunction

   // Halfwords need an even address, words a multiple of four
   function automatic logic misaligned(input logic [2:0] code, input logic [1:0] a);
      return (is_half(code) && a[0]) || (is_word(code) && (a != 2'b00));
   endfunction

   // Byte-lane enables for an access of this code at byte offset a
   function automatic logic [3:0] be_for(input logic [2:0] code, input logic [1:0] a);
      logic [3:0] be;
      if (is_word(code)) begin
         be = 4'b1111;
      end else if (is_half(code)) begin
         be = a[1] ? 4'b1100 : 4'b0011;
      end else begin
         be = 4'b0001 << a;
      end
      return be;
   endfunction

   // Store data replicated across all lanes so the enabled lanes carry it
   function automatic logic [31:0] wdata_for(input logic [2:0] code, input logic [31:0] wd);
      logic [31:0] r;
      if (is_word(code)) begin
         r = wd;
      end else if (is_half(code)) begin
         r = {2{wd[15:0]}};
      end else begin
         r = {4{wd[7:0]}};
      end
      return r;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load-data extractor: picks the addressed byte or halfword
// out of the returned memory word and sign- or zero-extends it.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [2:0]  ls_code_i,
   input  logic [1:0]  addr_lo_i,
   output logic [31:0] result_o
);

   logic [7:0]  lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata_i[8*gi +: 8];
   end

   assign byte_sel = lane[addr_lo_i];
   assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   // Size-dependent extraction and extension
   always_comb begin
      result_o = rdata_i;
      if (is_byte(ls_code_i)) begin
         if (is_signed_load(ls_code_i)) begin
            result_o = {{24{byte_sel[7]}}, byte_sel};
         end else begin
            result_o = {24'h000000, byte_sel};
         end
      end else if (is_half(ls_code_i)) begin
         if (is_signed_load(ls_code_i)) begin
            result_o = {{16{half_sel[15]}}, half_sel};
         end else begin
            result_o = {16'h0000, half_sel};
         end
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine. Accepts one operation at a time, raises
// address-error pulses for misaligned accesses, drives a single-outstanding
// req/gnt/rvalid memory port and returns extended load data to writeback.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        ls_code,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [4:0]        dst_reg,
   input  logic              flush,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rsp_valid,
   output logic              rsp_is_load,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [4:0]        rsp_dst,
   output logic              adel,
   output logic              ades,
   output logic [ADDR_W-1:0] bad_vaddr
);

   state_e            state_q;
   logic [2:0]        op_code_q;
   logic [1:0]        op_alo_q;
   logic [4:0]        op_dst_q;

   logic              mem_req_q;
   logic              mem_we_q;
   logic [3:0]        mem_be_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;

   logic              rsp_valid_q;
   logic              rsp_is_load_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic [4:0]        rsp_dst_q;

   logic              adel_q;
   logic              ades_q;
   logic [ADDR_W-1:0] bad_vaddr_q;

   logic              idle;
   logic              accept;
   logic              acc_misaligned;
   logic [DATA_W-1:0] load_result;

   assign idle           = (state_q == ST_IDLE);
   assign accept         = idle & req_valid & ~flush;
   assign acc_misaligned = misaligned(ls_code, addr[1:0]);

   // Extraction works from the registered code/offset of the in-flight load
   mem_load_align u_load_align (
      .rdata_i   (mem_rdata),
      .ls_code_i (op_code_q),
      .addr_lo_i (op_alo_q),
      .result_o  (load_result)
   );

   // Transaction FSM with all memory-side and response outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         op_code_q     <= LS_LB;
         op_alo_q      <= 2'b00;
         op_dst_q      <= 5'd0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_be_q      <= 4'b0000;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_is_load_q <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_dst_q     <= 5'd0;
         adel_q        <= 1'b0;
         ades_q        <= 1'b0;
         bad_vaddr_q   <= '0;
      end else begin
         // Completion and exception outputs are single-cycle pulses
         rsp_valid_q <= 1'b0;
         adel_q      <= 1'b0;
         ades_q      <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_code_q <= ls_code;
                  op_alo_q  <= addr[1:0];
                  op_dst_q  <= dst_reg;
                  if (acc_misaligned) begin
                     // Fault instead of issuing; FSM stays idle
                     adel_q      <= ~is_store(ls_code);
                     ades_q      <= is_store(ls_code);
                     bad_vaddr_q <= addr;
                  end else begin
                     state_q     <= ST_REQ;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= is_store(ls_code);
                     mem_be_q    <= be_for(ls_code, addr[1:0]);
                     mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                     mem_wdata_q <= wdata_for(ls_code, wdata);
                  end
               end
            end

            ST_REQ: begin
               if (mem_gnt) begin
                  // Granted: the access is committed even under flush
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  if (is_store(op_code_q)) begin
                     state_q <= ST_IDLE;
                     if (!flush) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_is_load_q <= 1'b0;
                        rsp_rdata_q   <= '0;
                        rsp_dst_q     <= 5'd0;
                     end
                  end else begin
                     state_q <= flush ? ST_DRAIN : ST_WAIT;
                  end
               end else if (flush) begin
                  // Not yet granted: simply withdraw the request
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end

            ST_WAIT: begin
               if (mem_rvalid) begin
                  state_q <= ST_IDLE;
                  if (!flush) begin
                     rsp_valid_q   <= 1'b1;
                     rsp_is_load_q <= 1'b1;
                     rsp_rdata_q   <= load_result;
                     rsp_dst_q     <= op_dst_q;
                  end
               end else if (flush) begin
                  state_q <= ST_DRAIN;
               end
            end

            ST_DRAIN: begin
               // Read data of a flushed load is consumed and dropped
               if (mem_rvalid) begin
                  state_q <= ST_IDLE;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready   = idle & ~rst;
   assign stall       = ~rst & ((req_valid & ~req_ready) | ~idle);

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_be      = mem_be_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;

   assign rsp_valid   = rsp_valid_q;
   assign rsp_is_load = rsp_is_load_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_dst     = rsp_dst_q;

   // A flush arriving while the fault pulse is up cancels it
   assign adel        = adel_q & ~flush & ~rst;
   assign ades        = ades_q & ~flush & ~rst;
   assign bad_vaddr   = bad_vaddr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed scenarios for timing and
// flush/reset corners, then randomized traffic checked against a size/offset
// arithmetic model of the load/store rules.
module tb_mem_access_unit;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   localparam logic [2:0] C_LB  = 3'd0;
   localparam logic [2:0] C_LBU = 3'd1;
   localparam logic [2:0] C_LH  = 3'd2;
   localparam logic [2:0] C_LHU = 3'd3;
   localparam logic [2:0] C_LW  = 3'd4;
   localparam logic [2:0] C_SH  = 3'd6;
   localparam logic [2:0] C_SW  = 3'd7;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        ls_code;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [4:0]        dst_reg;
   logic              flush;
   logic              stall;
   logic              mem_req;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   logic              rsp_valid;
   logic              rsp_is_load;
   logic [DATA_W-1:0] rsp_rdata;
   logic [4:0]        rsp_dst;
   logic              adel;
   logic              ades;
   logic [ADDR_W-1:0] bad_vaddr;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .ls_code     (ls_code),
      .addr        (addr),
      .wdata       (wdata),
      .dst_reg     (dst_reg),
      .flush       (flush),
      .stall       (stall),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_be      (mem_be),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .rsp_valid   (rsp_valid),
      .rsp_is_load (rsp_is_load),
      .rsp_rdata   (rsp_rdata),
      .rsp_dst     (rsp_dst),
      .adel        (adel),
      .ades        (ades),
      .bad_vaddr   (bad_vaddr)
   );

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mreq_t;

   typedef struct {
      logic        is_load;
      logic [31:0] rdata;
      logic [4:0]  dst;
   } rsp_t;

   typedef struct {
      logic        is_load;
      logic [31:0] va;
   } exc_t;

   mreq_t mreq_q[$];
   rsp_t  rsp_q[$];
   exc_t  exc_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- reference model (size/offset arithmetic) ----------------
   function automatic int unsigned ref_size(input logic [2:0] c);
      case (c)
         3'd0, 3'd1, 3'd5: return 1;
         3'd2, 3'd3, 3'd6: return 2;
         default:          return 4;
      endcase
   endfunction

   function automatic logic ref_is_store(input logic [2:0] c);
      return c >= 3'd5;
   endfunction

   function automatic logic ref_misaligned(input logic [2:0] c, input logic [31:0] a);
      return (a % ref_size(c)) != 0;
   endfunction

   // First byte lane of the access, offset rounded down to the access size
   function automatic int unsigned ref_lane(input logic [2:0] c, input logic [31:0] a);
      return (a % 4) - ((a % 4) % ref_size(c));
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] c, input logic [31:0] a);
      int unsigned m;
      m = ((32'd1 << ref_size(c)) - 1) << ref_lane(c, a);
      return m[3:0];
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] c, input logic [31:0] wd);
      case (ref_size(c))
         1:       return (wd & 32'hFF) * 32'h0101_0101;
         2:       return (wd & 32'hFFFF) * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] c, input logic [31:0] a,
                                            input logic [31:0] rd);
      int unsigned sz;
      int unsigned bits;
      logic [31:0] mask;
      logic [31:0] v;
      sz   = ref_size(c);
      bits = 8 * sz;
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
      v    = (rd >> (8 * ref_lane(c, a))) & mask;
      if (((c == C_LB) || (c == C_LH)) && v[bits-1]) begin
         v = v | ~mask;
      end
      return v;
   endfunction

   // ---------------- monitor: pops expectations when the DUT presents output ----------------
   mreq_t em;
   rsp_t  er;
   exc_t  ex;

   // Checks every handshake, response and fault pulse against the queues
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_req && mem_gnt) begin
            if (mreq_q.size() == 0) begin
               check("unexpected_mem_handshake", 32'(mem_req), 32'd0);
            end else begin
               em = mreq_q.pop_front();
               check("mem_we", 32'(mem_we), 32'(em.we));
               check("mem_be", 32'(mem_be), 32'(em.be));
               check("mem_addr", mem_addr, em.addr);
               if (em.we) begin
                  check("mem_wdata", mem_wdata, em.wdata);
               end
            end
         end
         if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
               check("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
               er = rsp_q.pop_front();
               check("rsp_is_load", 32'(rsp_is_load), 32'(er.is_load));
               check("rsp_rdata", rsp_rdata, er.rdata);
               if (er.is_load) begin
                  check("rsp_dst", 32'(rsp_dst), 32'(er.dst));
               end
            end
         end
         if (adel || ades) begin
            if (exc_q.size() == 0) begin
               check("unexpected_addr_error", {30'd0, adel, ades}, 32'd0);
            end else begin
               ex = exc_q.pop_front();
               check("adel", 32'(adel), 32'(ex.is_load));
               check("ades", 32'(ades), 32'(!ex.is_load));
               check("bad_vaddr", bad_vaddr, ex.va);
            end
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] d);
      req_valid = 1'b1;
      ls_code   = c;
      addr      = a;
      wdata     = wd;
      dst_reg   = d;
      cyc();
      req_valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      @(negedge clk);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_stall"}, 32'(stall), 32'd0);
      check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
      check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      check({tag, "_mem_be"}, 32'(mem_be), 32'd0);
      check({tag, "_mem_addr"}, mem_addr, 32'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rsp_is_load"}, 32'(rsp_is_load), 32'd0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      check({tag, "_rsp_dst"}, 32'(rsp_dst), 32'd0);
      check({tag, "_adel_ades"}, {30'd0, adel, ades}, 32'd0);
      check({tag, "_bad_vaddr"}, bad_vaddr, 32'd0);
   endtask

   // Aligned access with gnt at cycle 1 and (for loads) rvalid at cycle 2
   task automatic dir_access(input string tag, input logic [2:0] c, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd);
      req_valid = 1'b1;
      ls_code   = c;
      addr      = a;
      wdata     = wd;
      dst_reg   = 5'd7;
      @(negedge clk);
      check({tag, "_ready_c0"}, 32'(req_ready), 32'd1);
      cyc();
      req_valid = 1'b0;
      mem_gnt   = 1'b1;
      @(negedge clk);
      check({tag, "_mem_req_c1"}, 32'(mem_req), 32'd1);
      cyc();
      mem_gnt = 1'b0;
      if (!ref_is_store(c)) begin
         mem_rvalid = 1'b1;
         mem_rdata  = rd;
         @(negedge clk);
         check({tag, "_rsp_c2"}, 32'(rsp_valid), 32'd0);
         cyc();
         mem_rvalid = 1'b0;
         @(negedge clk);
         check({tag, "_rsp_c3"}, 32'(rsp_valid), 32'd1);
      end else begin
         @(negedge clk);
         check({tag, "_rsp_c2"}, 32'(rsp_valid), 32'd1);
      end
      cyc();
   endtask

   // Randomized transaction; mode 2 flushes before grant, mode 3 flushes at grant/wait
   task automatic run_txn(input int idx, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] d, input logic [31:0] rd,
                          input int gdly, input int rdly, input int mode);
      logic is_ld;
      is_ld = !ref_is_store(c);
      $display("txn %0d code=%0d addr=%08h wdata=%08h rdata=%08h gdly=%0d rdly=%0d mode=%0d",
               idx, c, a, wd, rd, gdly, rdly, mode);
      if (ref_misaligned(c, a)) begin
         if (mode != 2) begin
            exc_q.push_back('{is_load: is_ld, va: a});
         end
         present(c, a, wd, d);
         if (mode == 2) begin
            flush = 1'b1;
         end
         mem_rvalid = 1'($urandom_range(0, 1));
         cyc();
         flush      = 1'b0;
         mem_rvalid = 1'b0;
         return;
      end
      if (mode != 2) begin
         mreq_q.push_back('{we: !is_ld, be: ref_be(c, a), addr: {a[31:2], 2'b00},
                            wdata: ref_wdata(c, wd)});
         if (mode != 3) begin
            rsp_q.push_back('{is_load: is_ld, rdata: is_ld ? ref_load(c, a, rd) : 32'd0, dst: d});
         end
      end
      present(c, a, wd, d);
      repeat (gdly) cyc();
      if (mode == 2) begin
         flush = 1'b1;
         cyc();
         flush = 1'b0;
         return;
      end
      mem_gnt = 1'b1;
      if (!is_ld && mode == 3) begin
         flush = 1'b1;
      end
      cyc();
      mem_gnt = 1'b0;
      flush   = 1'b0;
      if (!is_ld) begin
         return;
      end
      for (int k = 0; k < rdly; k++) begin
         if (mode == 3 && k == 0) begin
            flush = 1'b1;
         end
         cyc();
         flush = 1'b0;
      end
      if (mode == 3 && rdly == 0) begin
         flush = 1'b1;
      end
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
      cyc();
      mem_rvalid = 1'b0;
      flush      = 1'b0;
      mem_rdata  = $urandom;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Main stimulus sequence
   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      flush      = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      ls_code    = 3'd0;
      addr       = '0;
      wdata      = '0;
      dst_reg    = '0;
      mem_rdata  = '0;

      // Reset state
      repeat (3) @(posedge clk);
      check_all_zero("reset");
      cyc();
      rst = 1'b0;
      cyc();

      // lb / lbu at 0x1003
      $display("dir lb 0x1003");
      mreq_q.push_back('{we: 1'b0, be: 4'b1000, addr: 32'h1000, wdata: 32'h0});
      rsp_q.push_back('{is_load: 1'b1, rdata: 32'hFFFF_FF80, dst: 5'd7});
      dir_access("lb", C_LB, 32'h1003, 32'h0, 32'h80FF_1234);
      $display("dir lbu 0x1003");
      mreq_q.push_back('{we: 1'b0, be: 4'b1000, addr: 32'h1000, wdata: 32'h0});
      rsp_q.push_back('{is_load: 1'b1, rdata: 32'h0000_0080, dst: 5'd7});
      dir_access("lbu", C_LBU, 32'h1003, 32'h0, 32'h80FF_1234);

      // sh at 0x2002
      $display("dir sh 0x2002");
      mreq_q.push_back('{we: 1'b1, be: 4'b1100, addr: 32'h2000, wdata: 32'hABCD_ABCD});
      rsp_q.push_back('{is_load: 1'b0, rdata: 32'h0, dst: 5'd0});
      dir_access("sh", C_SH, 32'h2002, 32'h0000_ABCD, 32'h0);

      // Misaligned lw / sw
      $display("dir lw 0x3001 misaligned");
      exc_q.push_back('{is_load: 1'b1, va: 32'h3001});
      present(C_LW, 32'h3001, 32'h0, 5'd3);
      @(negedge clk);
      check("lw_mis_adel_c1", 32'(adel), 32'd1);
      check("lw_mis_no_mem_req", 32'(mem_req), 32'd0);
      cyc();
      $display("dir sw 0x3002 misaligned");
      exc_q.push_back('{is_load: 1'b0, va: 32'h3002});
      present(C_SW, 32'h3002, 32'h1234_5678, 5'd0);
      @(negedge clk);
      check("sw_mis_ades_c1", 32'(ades), 32'd1);
      check("sw_mis_no_mem_req", 32'(mem_req), 32'd0);
      cyc();

      // Flush during the fault pulse cancels it
      $display("dir lh 0x3003 misaligned with flush");
      present(C_LH, 32'h3003, 32'h0, 5'd4);
      flush = 1'b1;
      @(negedge clk);
      check("flush_suppress_adel", 32'(adel), 32'd0);
      cyc();
      flush = 1'b0;

      // Grant stall: five cycles without gnt
      $display("dir sw 0x4000 grant stall");
      mreq_q.push_back('{we: 1'b1, be: 4'b1111, addr: 32'h4000, wdata: 32'hC0DE_F00D});
      rsp_q.push_back('{is_load: 1'b0, rdata: 32'h0, dst: 5'd0});
      present(C_SW, 32'h4000, 32'hC0DE_F00D, 5'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("gstall_mem_req", 32'(mem_req), 32'd1);
         check("gstall_mem_we", 32'(mem_we), 32'd1);
         check("gstall_mem_be", 32'(mem_be), 32'hF);
         check("gstall_mem_addr", mem_addr, 32'h4000);
         check("gstall_mem_wdata", mem_wdata, 32'hC0DE_F00D);
         check("gstall_stall", 32'(stall), 32'd1);
         check("gstall_req_ready", 32'(req_ready), 32'd0);
         cyc();
      end
      mem_gnt = 1'b1;
      cyc();
      mem_gnt = 1'b0;
      cyc();

      // Flush in WAIT: lhu, flush at cycle 2, rvalid at cycle 4
      $display("dir lhu 0x5002 flush in wait");
      mreq_q.push_back('{we: 1'b0, be: 4'b1100, addr: 32'h5000, wdata: 32'h0});
      present(C_LHU, 32'h5002, 32'h0, 5'd9);
      mem_gnt = 1'b1;
      cyc();
      mem_gnt = 1'b0;
      flush   = 1'b1;
      cyc();
      flush = 1'b0;
      @(negedge clk);
      check("fwait_ready_c3", 32'(req_ready), 32'd0);
      cyc();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1234_5678;
      @(negedge clk);
      check("fwait_ready_c4", 32'(req_ready), 32'd0);
      cyc();
      mem_rvalid = 1'b0;
      @(negedge clk);
      check("fwait_ready_c5", 32'(req_ready), 32'd1);
      check("fwait_no_rsp_c5", 32'(rsp_valid), 32'd0);
      cyc();

      // Reset while a request waits for grant
      $display("dir lw 0x6000 reset in req");
      present(C_LW, 32'h6000, 32'h0, 5'd1);
      @(negedge clk);
      check("rstreq_mem_req_c1", 32'(mem_req), 32'd1);
      cyc();
      rst = 1'b1;
      cyc();
      check_all_zero("rst_in_req");
      cyc();
      rst = 1'b0;
      cyc();

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         run_txn(i, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                 $urandom, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3));
      end

      repeat (4) cyc();
      check("mreq_queue_drained", 32'(mreq_q.size()), 32'd0);
      check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
      check("exc_queue_drained", 32'(exc_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store engine. Consumes the 3-bit unified load/store code produced by instruction decode together with the effective address and store data. Drives a single-outstanding request/grant/response data-memory port and returns aligned, sign- or zero-extended load data to writeback. Flags address-error exceptions (AdEL/AdES) instead of issuing misaligned accesses, and stalls the pipeline while a transaction is in flight.

## Interface

- ADDR_W, 32: address width. The alignment logic uses bits [1:0].
- DATA_W, 32: data width. Fixed at 32; other values are unsupported.

Ports:

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  memory operation presented by EX/MEM.
- req_ready  out  1  unit idle and able to accept.
- ls_code  in  3  load/store code: 000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw, 101 sb, 110 sh, 111 sw.
- addr  in  ADDR_W  effective byte address.
- wdata  in  DATA_W  store data, right-justified.
- dst_reg  in  5  load destination tag, passed through to the response.
- flush  in  1  pipeline flush (exception or eret).
- stall  out  1  request held, or transaction in flight.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_W  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read word.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_is_load  out  1  completed operation was a load.
- rsp_rdata  out  DATA_W  extended load data (0 for stores).
- rsp_dst  out  5  tag of the completed load.
- adel  out  1  one-cycle pulse: misaligned load.
- ades  out  1  one-cycle pulse: misaligned store.
- bad_vaddr  out  ADDR_W  faulting address, valid with adel or ades.

## Operation

- **States:** IDLE, REQ, WAIT, DRAIN.
- **Accept:** in IDLE, req_valid & ~flush accepts the operation. req_ready = (state==IDLE) & ~rst.
  - stall = (req_valid & ~req_ready) | (state!=IDLE).
  - ls_code, addr, wdata and dst_reg are registered on acceptance.
- **Misalignment:**
  - halfword (lh, lhu, sh) with addr[0]=1 is misaligned.
  - word (lw, sw) with addr[1:0]≠0 is misaligned.
  - A misaligned operation issues no memory request. The cycle after acceptance, adel (loads) or ades (stores) pulses, with bad_vaddr=addr. The FSM stays in IDLE.
- **Byte enables and store data:**
  - sb: be=4'b0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
  - sh: be=addr[1]?4'b1100:4'b0011; wdata={2{wdata[15:0]}}.
  - sw: be=4'b1111.
  - Loads drive the same be pattern with mem_we=0.
- **Aligned access:** IDLE→REQ. mem_req and all mem_* outputs are registered and held stable until mem_gnt.
  - Store: on mem_gnt, REQ→IDLE; rsp_valid pulses next cycle with rsp_is_load=0.
  - Load: on mem_gnt, REQ→WAIT. On mem_rvalid, WAIT→IDLE; rsp_valid pulses next cycle.
- **Load extraction:**
  - byte: b=mem_rdata[8*a[1:0]+:8]. lb sign-extends; lbu zero-extends.
  - half: h=mem_rdata[16*a[1]+:16]. lh sign-extends; lhu zero-extends.
  - lw: full word.
- **Flush:**
  - In REQ without gnt: mem_req drops next cycle, go to IDLE, no response.
  - In REQ with gnt in the same cycle: the access is committed. A store completes with rsp suppressed; a load goes to DRAIN.
  - In WAIT: go to DRAIN. If mem_rvalid arrives in the same cycle, go directly to IDLE and discard the data.
  - DRAIN: wait for mem_rvalid, discard the data, return to IDLE; no rsp.
  - A flush during a pending adel/ades pulse suppresses the pulse.
- mem_rvalid outside WAIT/DRAIN is ignored.

## Timing

- **Reset:** while rst is high, state=IDLE and all outputs are 0, including req_ready. bad_vaddr, rsp_rdata and rsp_dst clear to 0.
- **Cycle numbering:** acceptance is at cycle 0.
  - mem_req earliest at cycle 1.
  - Store with gnt at cycle 1: rsp_valid at cycle 2.
  - Load with gnt at cycle 1 and rvalid at cycle 2: rsp_valid at cycle 3.
  - Exception pulse at cycle 1.
- mem_rvalid is never expected in the same cycle as mem_gnt; the earliest is the next cycle.
- **Response outputs:** rsp_rdata, rsp_dst and rsp_is_load are registered and held until the next response.
- **Throughput:** back-to-back accept is possible in the cycle rsp_valid pulses, because the FSM is already in IDLE.
- **Reset mid-transaction:** state returns to IDLE with no response. The memory side must tolerate the abandoned request.

## Structure

- **Shared package `mem_pkg`:**
  - LS_* code constants (LS_LB…LS_SW).
  - state enum.
  - be_for(code, a) function.
  - is_store/is_half/is_word helpers.
- **Sub-module `mem_load_align`:** combinational extractor (rdata, ls_code, addr[1:0] → 32-bit result). Instantiated once; unit-tested standalone.

## Test plan

- **lb at 0x1003:** mem_rdata=0x80FF_1234, gnt at cycle 1, rvalid at cycle 2 → rsp_valid at cycle 3, rsp_rdata=0xFFFF_FF80. Same access with lbu → 0x0000_0080.
- **sh at 0x2002:** wdata=0x0000_ABCD → mem_be=1100, mem_wdata=0xABCD_ABCD, mem_addr=0x2000, mem_we=1; rsp_valid the cycle after gnt, with rsp_is_load=0.
- **lw at 0x3001:** → no mem_req, adel=1 at cycle 1, bad_vaddr=0x3001. sw at 0x3002 → ades=1 instead.
- **Grant stall:** mem_gnt held low for 5 cycles → mem_req and all mem_* outputs stable, stall=1 throughout, req_ready=0.
- **Flush in WAIT:** lhu issued, flush at cycle 2, rvalid at cycle 4 → DRAIN; no rsp_valid; req_ready returns at cycle 5.
- **Reset:** rst asserted in REQ → next cycle mem_req=0, state IDLE, all outputs 0.
